// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller.
//   - ALU opcode and function codes of the vector ALU (R-type)
//   - element width encodings, latency classes and controller states
//   - has_zero_lane(): true when any WW-sized lane of a 64-bit operand is zero
package alu_issue_ctrl_pkg;

  localparam logic [0:5] ALU_OPCODE = 6'b101010;

  localparam logic [0:5] F_VAND   = 6'd1;
  localparam logic [0:5] F_VMULEU = 6'd8;
  localparam logic [0:5] F_VMULOU = 6'd9;
  localparam logic [0:5] F_VDIV   = 6'd14;
  localparam logic [0:5] F_VMOD   = 6'd15;
  localparam logic [0:5] F_VSQEU  = 6'd16;
  localparam logic [0:5] F_VSQOU  = 6'd17;
  localparam logic [0:5] F_VSQRT  = 6'd18;
  localparam logic [0:5] F_MAX    = F_VSQRT;

  localparam logic [0:1] WW_8  = 2'b00;
  localparam logic [0:1] WW_16 = 2'b01;
  localparam logic [0:1] WW_32 = 2'b10;
  localparam logic [0:1] WW_64 = 2'b11;

  typedef enum logic [1:0] {LAT_ONE, LAT_MUL, LAT_DIV} lat_class_e;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

  // Lane 0 sits at bit 0 (MSB end); lane order does not matter for "any zero".
  function automatic logic has_zero_lane(input logic [0:63] v, input logic [0:1] ww);
    logic z;
    z = 1'b0;
    case (ww)
      WW_8:    for (int i = 0; i < 8; i++) if (v[8*i +: 8] == 8'd0) z = 1'b1;
      WW_16:   for (int i = 0; i < 4; i++) if (v[16*i +: 16] == 16'd0) z = 1'b1;
      WW_32:   for (int i = 0; i < 2; i++) if (v[32*i +: 32] == 32'd0) z = 1'b1;
      default: z = (v == 64'd0);
    endcase
    return z;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_lat_decode.sv
// Combinational decode of opcode/func into legality, latency class and
// divide flag. Kept separate so hazard logic can reuse it.
//   opcode, func : instruction fields
//   illegal      : opcode is not the ALU opcode, or func is 0 or above VSQRT
//   lat_class    : LAT_ONE / LAT_MUL / LAT_DIV
//   is_div       : VDIV or VMOD (ops that need the divide-by-zero check)
module alu_issue_ctrl_lat_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [0:5]  opcode,
  input  logic [0:5]  func,
  output logic        illegal,
  output lat_class_e  lat_class,
  output logic        is_div
);

  always_comb begin
    illegal   = (opcode != ALU_OPCODE) || (func == 6'd0) || (func > F_MAX);
    is_div    = (func == F_VDIV) || (func == F_VMOD);
    lat_class = LAT_ONE;
    case (func)
      F_VMULEU, F_VMULOU, F_VSQEU, F_VSQOU: lat_class = LAT_MUL;
      F_VDIV, F_VMOD, F_VSQRT:              lat_class = LAT_DIV;
      default:                              lat_class = LAT_ONE;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller in front of the combinational vector ALU.
// Accepts one request at a time, holds operands on the ALU inputs for the
// op's latency, captures the ALU result and returns it with its tag.
//   clk, reset          : clock, synchronous active-high reset
//   req_*               : request handshake and payload (opcode/func/ww/rA/rB/tag)
//   alu_*               : registered operands to the ALU, alu_out result back
//   rsp_*               : response handshake, data, tag, illegal/divzero flags
//
// state   | meaning
// IDLE    | req_ready=1, waiting for a request
// EXEC    | operands held on ALU, latency counter running down
// RESP    | result held; rsp_valid raised one cycle after entry, held until rsp_ready
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [0:5]       req_opcode,
  input  logic [0:5]       req_func,
  input  logic [0:1]       req_ww,
  input  logic [0:63]      req_rA,
  input  logic [0:63]      req_rB,
  input  logic [TAG_W-1:0] req_tag,
  output logic [0:63]      alu_rA,
  output logic [0:63]      alu_rB,
  output logic [0:5]       alu_func,
  output logic [0:5]       alu_opcode,
  output logic [0:1]       alu_ww,
  input  logic [0:63]      alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [0:63]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal,
  output logic             rsp_divzero
);

  state_e     state;
  logic [3:0] cnt;
  logic [3:0] lat_m1;
  logic       dec_illegal;
  logic       dec_is_div;
  lat_class_e dec_lat;

  alu_issue_ctrl_lat_decode u_lat_decode (
    .opcode    (req_opcode),
    .func      (req_func),
    .illegal   (dec_illegal),
    .lat_class (dec_lat),
    .is_div    (dec_is_div)
  );

  always_comb begin
    case (dec_lat)
      LAT_MUL: lat_m1 = 4'(MUL_LAT - 1);
      LAT_DIV: lat_m1 = 4'(DIV_LAT - 1);
      default: lat_m1 = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      req_ready   <= 1'b1;
      alu_rA      <= '0;
      alu_rB      <= '0;
      alu_func    <= '0;
      alu_opcode  <= '0;
      alu_ww      <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_tag     <= '0;
      rsp_illegal <= 1'b0;
      rsp_divzero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            rsp_tag   <= req_tag;
            if (dec_illegal) begin
              // Nothing is sent to the ALU; respond with zero data.
              alu_rA      <= '0;
              alu_rB      <= '0;
              alu_func    <= '0;
              alu_opcode  <= '0;
              alu_ww      <= '0;
              rsp_data    <= '0;
              rsp_illegal <= 1'b1;
              rsp_divzero <= 1'b0;
              state       <= ST_RESP;
            end else begin
              alu_rA      <= req_rA;
              alu_rB      <= req_rB;
              alu_func    <= req_func;
              alu_opcode  <= req_opcode;
              alu_ww      <= req_ww;
              cnt         <= lat_m1;
              rsp_illegal <= 1'b0;
              rsp_divzero <= dec_is_div && has_zero_lane(req_rB, req_ww);
              state       <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == 4'd0) begin
            rsp_data <= alu_out;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          // rsp_valid is raised on the first RESP cycle so ready never
          // reaches valid combinationally.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_divzero <= 1'b0;
            req_ready   <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 8;
  localparam int TAG_W   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [0:5]       req_opcode = '0;
  logic [0:5]       req_func = '0;
  logic [0:1]       req_ww = '0;
  logic [0:63]      req_rA = '0;
  logic [0:63]      req_rB = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [0:63]      alu_rA, alu_rB, alu_out;
  logic [0:5]       alu_func, alu_opcode;
  logic [0:1]       alu_ww;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [0:63]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal, rsp_divzero;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [0:63]      data;
    logic [TAG_W-1:0] tag;
    logic             ill;
    logic             dz;
    int               lat;
  } exp_t;

  exp_t sb[$];

  alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_func(req_func), .req_ww(req_ww),
    .req_rA(req_rA), .req_rB(req_rB), .req_tag(req_tag),
    .alu_rA(alu_rA), .alu_rB(alu_rB), .alu_func(alu_func),
    .alu_opcode(alu_opcode), .alu_ww(alu_ww), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal), .rsp_divzero(rsp_divzero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALU: lane-wise AND/DIV/MOD are exact (x/0 = 0), other ops XOR.
  function automatic logic [0:63] alu_model(input logic [0:5] f, input logic [0:1] ww,
                                            input logic [0:63] a, input logic [0:63] b);
    logic [63:0] av, bv, r, la, lb, lr, mask;
    int w, n, sh;
    av = a; bv = b; r = 64'd0;
    w = 8 << ww;
    n = 64 / w;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    for (int i = 0; i < n; i++) begin
      sh = 64 - w * (i + 1);
      la = (av >> sh) & mask;
      lb = (bv >> sh) & mask;
      case (f)
        6'd1:    lr = la & lb;
        6'd14:   lr = (lb == 64'd0) ? 64'd0 : la / lb;
        6'd15:   lr = (lb == 64'd0) ? 64'd0 : la % lb;
        default: lr = la ^ lb;
      endcase
      r = r | ((lr & mask) << sh);
    end
    return r;
  endfunction

  always_comb alu_out = alu_model(alu_func, alu_ww, alu_rA, alu_rB);

  task automatic issue(input logic [0:5] op, input logic [0:5] f, input logic [0:1] ww,
                       input logic [0:63] a, input logic [0:63] b, input logic [TAG_W-1:0] tag,
                       output int acc);
    @(negedge clk);
    req_opcode = op; req_func = f; req_ww = ww; req_rA = a; req_rB = b; req_tag = tag;
    req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      if (req_ready === 1'b1) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output bit got, output int at);
    got = 1'b0; at = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1; at = cyc;
        break;
      end
    end
  endtask

  task automatic ack();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_tag, rsp_illegal, rsp_divzero, alu_rA, alu_rB, alu_func, alu_opcode, alu_ww} !== '0)
      $display("FAIL reset_outputs: got rsp_valid=%b rsp_data=%h alu_rA=%h want all zero", rsp_valid, rsp_data, alu_rA);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL reset_release: got req_ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_simple();
    int acc, at; bit got; exp_t e;
    sb.push_back('{64'd14, 4'd5, 1'b0, 1'b0, 2});
    issue(6'b101010, 6'd1, 2'b10, 64'd15, 64'd14, 4'd5, acc);
    get_rsp(got, at);
    e = sb.pop_front();
    n_checks++;
    if (!got || acc < 0 || at - acc != e.lat) $display("FAIL vand_latency: got %0d want %0d", at - acc, e.lat);
    else n_pass++;
    n_checks++;
    if (rsp_data !== e.data) $display("FAIL vand_data: got %h want %h", rsp_data, e.data);
    else n_pass++;
    n_checks++;
    if ({rsp_tag, rsp_illegal, rsp_divzero} !== {e.tag, e.ill, e.dz})
      $display("FAIL vand_tag_flags: got %h %b %b want %h %b %b", rsp_tag, rsp_illegal, rsp_divzero, e.tag, e.ill, e.dz);
    else n_pass++;
    ack();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_illegal !== 1'b0)
      $display("FAIL vand_handshake: got rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready);
    else n_pass++;
  endtask

  task automatic test_div_hold();
    int acc, at; bit got; exp_t e; bit held;
    logic [0:63] a, b;
    a = 64'hFF00FF00_FF00FF00;
    b = 64'h11221122_44444444;
    sb.push_back('{64'h0F000F00_03000300, 4'd6, 1'b0, 1'b0, DIV_LAT + 1});
    issue(6'b101010, 6'd14, 2'b00, a, b, 4'd6, acc);
    got = 1'b0; at = -1; held = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (alu_rA !== a || alu_rB !== b || alu_func !== 6'd14 || alu_opcode !== 6'b101010 || alu_ww !== 2'b00)
        held = 1'b0;
      if (rsp_valid === 1'b1) begin got = 1'b1; at = cyc; break; end
    end
    e = sb.pop_front();
    n_checks++;
    if (!held) $display("FAIL vdiv_alu_hold: got alu_rA=%h alu_rB=%h want %h %h", alu_rA, alu_rB, a, b);
    else n_pass++;
    n_checks++;
    if (!got || acc < 0 || at - acc != e.lat) $display("FAIL vdiv_latency: got %0d want %0d", at - acc, e.lat);
    else n_pass++;
    n_checks++;
    if ({rsp_data, rsp_tag, rsp_illegal, rsp_divzero} !== {e.data, e.tag, e.ill, e.dz})
      $display("FAIL vdiv_result: got %h %h %b %b want %h %h %b %b", rsp_data, rsp_tag, rsp_illegal, rsp_divzero,
               e.data, e.tag, e.ill, e.dz);
    else n_pass++;
    ack();
  endtask

  task automatic test_divzero();
    logic [0:5]  f_t [5];
    logic [0:1]  ww_t [5];
    logic [0:63] rb_t [5];
    logic        dz_t [5];
    logic [0:63] d_t  [5];
    int acc, at; bit got; exp_t e;
    f_t[0] = 6'd15; ww_t[0] = 2'b00; rb_t[0] = 64'h0A;                  dz_t[0] = 1'b1; d_t[0] = 64'd2;
    f_t[1] = 6'd15; ww_t[1] = 2'b11; rb_t[1] = 64'h0A;                  dz_t[1] = 1'b0; d_t[1] = 64'd2;
    f_t[2] = 6'd15; ww_t[2] = 2'b10; rb_t[2] = 64'h0A;                  dz_t[2] = 1'b1; d_t[2] = 64'd2;
    f_t[3] = 6'd14; ww_t[3] = 2'b01; rb_t[3] = 64'h000A000A_000A000A;   dz_t[3] = 1'b0; d_t[3] = 64'd10;
    f_t[4] = 6'd1;  ww_t[4] = 2'b00; rb_t[4] = 64'h0;                   dz_t[4] = 1'b0; d_t[4] = 64'd0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{d_t[i], 4'(i + 8), 1'b0, dz_t[i], (f_t[i] == 6'd1) ? 2 : DIV_LAT + 1});
      issue(6'b101010, f_t[i], ww_t[i], 64'd102, rb_t[i], 4'(i + 8), acc);
      get_rsp(got, at);
      e = sb.pop_front();
      n_checks++;
      if (!got || acc < 0 || at - acc != e.lat) $display("FAIL dz%0d_latency: got %0d want %0d", i, at - acc, e.lat);
      else n_pass++;
      n_checks++;
      if (rsp_divzero !== e.dz || rsp_illegal !== 1'b0)
        $display("FAIL dz%0d_flag: got divzero=%b illegal=%b want %b 0", i, rsp_divzero, rsp_illegal, e.dz);
      else n_pass++;
      n_checks++;
      if (rsp_data !== e.data || rsp_tag !== e.tag)
        $display("FAIL dz%0d_data: got %h tag %h want %h tag %h", i, rsp_data, rsp_tag, e.data, e.tag);
      else n_pass++;
      ack();
    end
  endtask

  task automatic test_illegal();
    logic [0:5] op_t [3];
    logic [0:5] f_t  [3];
    int acc, at; bit got; exp_t e;
    op_t[0] = 6'b000000; f_t[0] = 6'd14;
    op_t[1] = 6'b101010; f_t[1] = 6'b010011;
    op_t[2] = 6'b101010; f_t[2] = 6'd0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{64'd0, 4'(i + 1), 1'b1, 1'b0, 1});
      issue(op_t[i], f_t[i], 2'b00, 64'hDEAD_BEEF_0123_4567, 64'd0, 4'(i + 1), acc);
      get_rsp(got, at);
      e = sb.pop_front();
      n_checks++;
      if (!got || acc < 0 || at - acc != e.lat) $display("FAIL ill%0d_latency: got %0d want %0d", i, at - acc, e.lat);
      else n_pass++;
      n_checks++;
      if ({rsp_data, rsp_tag, rsp_illegal, rsp_divzero} !== {e.data, e.tag, e.ill, e.dz})
        $display("FAIL ill%0d_result: got %h %h %b %b want %h %h %b %b", i, rsp_data, rsp_tag, rsp_illegal,
                 rsp_divzero, e.data, e.tag, e.ill, e.dz);
      else n_pass++;
      n_checks++;
      if ({alu_rA, alu_rB, alu_func, alu_opcode, alu_ww} !== '0)
        $display("FAIL ill%0d_alu_cleared: got alu_rA=%h alu_func=%h want 0", i, alu_rA, alu_func);
      else n_pass++;
      ack();
    end
  endtask

  task automatic test_back_to_back();
    int acc, at; bit got; exp_t e; bit stable;
    sb.push_back('{64'h1234 ^ 64'h00FF, 4'd9, 1'b0, 1'b0, MUL_LAT + 1});
    issue(6'b101010, 6'd8, 2'b11, 64'h1234, 64'h00FF, 4'd9, acc);
    get_rsp(got, at);
    e = sb.pop_front();
    n_checks++;
    if (!got || acc < 0 || at - acc != e.lat) $display("FAIL mul_latency: got %0d want %0d", at - acc, e.lat);
    else n_pass++;
    req_opcode = 6'b101010; req_func = 6'd1; req_ww = 2'b11;
    req_rA = 64'hF0F0; req_rB = 64'h0FF0; req_tag = 4'd10; req_valid = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_tag !== e.tag || req_ready !== 1'b0) stable = 1'b0;
    end
    n_checks++;
    if (!stable) $display("FAIL mul_backpressure: got rsp_valid=%b data=%h tag=%h req_ready=%b want 1 %h %h 0",
                          rsp_valid, rsp_data, rsp_tag, req_ready, e.data, e.tag);
    else n_pass++;
    sb.push_back('{64'h00F0, 4'd10, 1'b0, 1'b0, 2});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    acc = -1;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL mul_release: got rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready);
    else n_pass++;
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
    get_rsp(got, at);
    e = sb.pop_front();
    n_checks++;
    if (!got || at - acc != e.lat) $display("FAIL second_latency: got %0d want %0d", at - acc, e.lat);
    else n_pass++;
    n_checks++;
    if (rsp_data !== e.data || rsp_tag !== e.tag)
      $display("FAIL second_result: got %h tag %h want %h tag %h", rsp_data, rsp_tag, e.data, e.tag);
    else n_pass++;
    ack();
  endtask

  task automatic test_reset_mid_exec();
    int acc; bit stale;
    sb.push_back('{64'd0, 4'd3, 1'b0, 1'b0, DIV_LAT + 1});
    issue(6'b101010, 6'd18, 2'b10, 64'h1111_2222_3333_4444, 64'h5555, 4'd3, acc);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sb.delete();
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_tag, rsp_illegal, rsp_divzero, alu_rA, alu_rB, alu_func, alu_opcode, alu_ww} !== '0)
      $display("FAIL midreset_outputs: got rsp_valid=%b alu_rA=%h alu_func=%h rsp_tag=%h want all zero",
               rsp_valid, alu_rA, alu_func, rsp_tag);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL midreset_ready: got %b want 1", req_ready);
    else n_pass++;
    stale = 1'b0;
    for (int k = 0; k < DIV_LAT + 6; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stale = 1'b1;
    end
    n_checks++;
    if (stale) $display("FAIL midreset_stale_rsp: got rsp_valid=1 want 0");
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_simple();
    test_div_hold();
    test_divzero();
    test_illegal();
    test_back_to_back();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
